// File: rtl/mem_arb_types_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and grant-index width.
package mem_arb_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index width for a given port count; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational picker: first pending port found searching upward from start_i, wrapping.
// Fixed priority is simply start_i = 0.
module mem_arb_picker
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IW        = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending_i,
  input  logic [IW-1:0]        start_i,
  output logic [IW-1:0]        winner_o,
  output logic                 valid_o
);

  logic [IW:0] idx;

  // Walk offsets from farthest to nearest so the nearest pending port is written last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = {1'b0, start_i} + (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_PORTS)) begin
        idx = idx - (IW+1)'(NUM_PORTS);
      end
      if (pending_i[idx[IW-1:0]]) begin
        winner_o = idx[IW-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises NUM_PORTS mp1-style masters onto one memory port, one access at a time.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise fixed priority (lowest index wins).
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int BE_W      = DATA_WIDTH / 8,
  localparam int IW        = idx_w(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_PORTS-1:0]                  req_read,
  input  logic [NUM_PORTS-1:0]                  req_write,
  input  logic [NUM_PORTS-1:0][BE_W-1:0]        req_byte_enable,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_address,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]                  req_resp,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_rdata,
  output logic                                  mem_read,
  output logic                                  mem_write,
  output logic [BE_W-1:0]                       mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]                 mem_address,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_resp,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata,
  output logic                                  arb_busy,
  output logic [IW-1:0]                         arb_grant
);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [NUM_PORTS-1:0] pending;
  logic [IW-1:0]       start;
  logic [IW-1:0]       win_idx;
  logic                win_vld;

  assign pending = req_read | req_write;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] last_q, last_d;

  // Reset value NUM_PORTS-1 makes port 0 the first preferred requester.
  assign start = (last_q == IW'(NUM_PORTS - 1)) ? '0 : last_q + 1'b1;

  always_comb begin
    last_d = last_q;
    if (state_q == IDLE && win_vld) begin
      last_d = win_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= IW'(NUM_PORTS - 1);
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign start = '0;
`endif

  mem_arb_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_picker (
    .pending_i (pending),
    .start_i   (start),
    .winner_o  (win_idx),
    .valid_o   (win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
    mem_address     = '0;
    mem_wdata       = '0;
    req_resp        = '0;
    req_rdata       = '0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Strobes track the granted port live, so a dropped request drops the strobe too.
        mem_write            = req_write[grant_q];
        mem_read             = req_read[grant_q] & ~req_write[grant_q];
        mem_byte_enable      = req_byte_enable[grant_q];
        mem_address          = req_address[grant_q];
        mem_wdata            = req_wdata[grant_q];
        req_rdata[grant_q]   = mem_rdata;
        if (mem_resp) begin
          req_resp[grant_q] = 1'b1;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign arb_busy  = (state_q == BUSY);
  assign arb_grant = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (4 ports): directed cycle table, reset abort sequence, random run vs reference model.
module tb_mem_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
  localparam int GA = 1;
`else
  localparam bit RR = 1'b0;
  localparam int GA = 0;
`endif

  logic                      clk;
  logic                      rst;
  logic [NP-1:0]             req_read;
  logic [NP-1:0]             req_write;
  logic [NP-1:0][BW-1:0]     req_byte_enable;
  logic [NP-1:0][AW-1:0]     req_address;
  logic [NP-1:0][DW-1:0]     req_wdata;
  logic [NP-1:0]             req_resp;
  logic [NP-1:0][DW-1:0]     req_rdata;
  logic                      mem_read;
  logic                      mem_write;
  logic [BW-1:0]             mem_byte_enable;
  logic [AW-1:0]             mem_address;
  logic [DW-1:0]             mem_wdata;
  logic                      mem_resp;
  logic [DW-1:0]             mem_rdata;
  logic                      arb_busy;
  logic [1:0]                arb_grant;

  mem_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_byte_enable (req_byte_enable),
    .req_address     (req_address),
    .req_wdata       (req_wdata),
    .req_resp        (req_resp),
    .req_rdata       (req_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .arb_busy        (arb_busy),
    .arb_grant       (arb_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] rd;
    logic [3:0] wr;
    logic       mr;
    logic       erd;
    logic       ewr;
    logic [3:0] eresp;
    logic       ebusy;
    logic [1:0] eg;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  bit m_busy;
  int m_g;
  int m_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rd, input logic e_wr,
                            input logic [3:0] e_resp, input logic e_busy, input logic [1:0] e_g,
                            input logic [31:0] e_addr, input logic [31:0] e_wd,
                            input logic [3:0] e_be, input logic [127:0] e_rdata);
    chk({tag, ".mem_read"},  128'(mem_read),        128'(e_rd));
    chk({tag, ".mem_write"}, 128'(mem_write),       128'(e_wr));
    chk({tag, ".req_resp"},  128'(req_resp),        128'(e_resp));
    chk({tag, ".arb_busy"},  128'(arb_busy),        128'(e_busy));
    chk({tag, ".arb_grant"}, 128'(arb_grant),       128'(e_g));
    chk({tag, ".mem_addr"},  128'(mem_address),     128'(e_addr));
    chk({tag, ".mem_wdata"}, 128'(mem_wdata),       128'(e_wd));
    chk({tag, ".mem_be"},    128'(mem_byte_enable), 128'(e_be));
    chk({tag, ".req_rdata"}, 128'(req_rdata),       e_rdata);
  endtask

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input logic mr,
                              input logic erd, input logic ewr, input logic [3:0] eresp,
                              input logic ebusy, input int eg);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mr = mr; v.erd = erd; v.ewr = ewr;
    v.eresp = eresp; v.ebusy = ebusy; v.eg = 2'(eg);
    return v;
  endfunction

  // Spec rule: search from (last+1) mod NP; fixed priority equals searching from 0.
  function automatic int pick(input logic [3:0] p, input int last);
    for (int k = 1; k <= NP; k++) begin
      int i;
      i = (last + k) % NP;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_check(input string tag);
    logic [127:0] er;
    logic [3:0]   eresp;
    er    = '0;
    eresp = '0;
    if (m_busy) begin
      er[m_g*32 +: 32] = mem_rdata;
      if (mem_resp) eresp[m_g] = 1'b1;
      check_outs(tag, req_read[m_g] & ~req_write[m_g], req_write[m_g], eresp, 1'b1, 2'(m_g),
                 req_address[m_g], req_wdata[m_g], req_byte_enable[m_g], er);
    end else begin
      check_outs(tag, 1'b0, 1'b0, 4'b0, 1'b0, 2'(m_g), 32'h0, 32'h0, 4'h0, 128'h0);
    end
  endtask

  task automatic model_advance();
    int w;
    if (m_busy) begin
      if (mem_resp) m_busy = 1'b0;
    end else begin
      w = pick(req_read | req_write, RR ? m_last : NP - 1);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_g    = w;
        if (RR) m_last = w;
      end
    end
  endtask

  logic [3:0] ra;
  logic [3:0] act, cool;
  logic [1:0] kind;

  initial begin
    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    mem_resp = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    req_address[0] = 32'h0000_0100; req_address[1] = 32'h0000_0040;
    req_address[2] = 32'h0000_0200; req_address[3] = 32'h0000_0300;
    req_wdata[0] = 32'h1234_5678; req_wdata[1] = 32'h1111_1111;
    req_wdata[2] = 32'h2222_2222; req_wdata[3] = 32'h3333_3333;
    req_byte_enable[0] = 4'b0011; req_byte_enable[1] = 4'b1111;
    req_byte_enable[2] = 4'b0101; req_byte_enable[3] = 4'b1000;

    ra = 4'(1 << GA);
    // rd, wr, mem_resp | exp read, write, resp, busy, grant
    tbl.push_back(mk(4'b0010, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));   // single read, port 1
    tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 1, 1));
    tbl.push_back(mk(4'b0010, 4'b0000, 0, 1, 0, 4'b0000, 1, 1));
    tbl.push_back(mk(4'b0010, 4'b0000, 1, 1, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 1));   // spurious resp in IDLE
    tbl.push_back(mk(4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));   // contention 0/1
    tbl.push_back(mk(4'b0011, 4'b0000, 1, 1, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0011, 4'b0000, 1, 1, 0, ra,      1, GA));
    tbl.push_back(mk(4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 0, GA));
    tbl.push_back(mk(4'b0011, 4'b0000, 1, 1, 0, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b0011, 4'b0000, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b0011, 4'b0000, 1, 1, 0, ra,      1, GA));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, GA));
    tbl.push_back(mk(4'b0000, 4'b0001, 0, 0, 0, 4'b0000, 0, GA));  // write, port 0
    tbl.push_back(mk(4'b0000, 4'b0001, 0, 0, 1, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 0, 0, 1, 4'b0000, 1, 0));
    tbl.push_back(mk(4'b0000, 4'b0001, 1, 0, 1, 4'b0001, 1, 0));
    tbl.push_back(mk(4'b1000, 4'b1000, 0, 0, 0, 4'b0000, 0, 0));   // read+write: write wins
    tbl.push_back(mk(4'b1000, 4'b1000, 1, 0, 1, 4'b1000, 1, 3));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(4'b1010, 4'b0000, 0, 0, 0, 4'b0000, 0, 3));   // wrap from last=3
    tbl.push_back(mk(4'b1010, 4'b0000, 1, 1, 0, 4'b0010, 1, 1));
    tbl.push_back(mk(4'b1000, 4'b0000, 0, 0, 0, 4'b0000, 0, 1));
    tbl.push_back(mk(4'b1000, 4'b0000, 1, 1, 0, 4'b1000, 1, 3));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 3));
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 0, 0, 4'b0000, 0, 3));   // port 2 drops early
    tbl.push_back(mk(4'b0100, 4'b0000, 0, 1, 0, 4'b0000, 1, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 1, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0100, 1, 2));
    tbl.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 2));

    #2;
    check_outs("reset", 0, 0, 4'b0, 0, 2'd0, 32'h0, 32'h0, 4'h0, 128'h0);
    step();
    step();
    rst = 1'b0;

    foreach (tbl[n]) begin
      logic [127:0] er;
      int g;
      req_read  = tbl[n].rd;
      req_write = tbl[n].wr;
      mem_resp  = tbl[n].mr;
      #1;
      g  = int'(tbl[n].eg);
      er = '0;
      if (tbl[n].ebusy) er[g*32 +: 32] = 32'hDEAD_BEEF;
      check_outs($sformatf("vec%0d", n), tbl[n].erd, tbl[n].ewr, tbl[n].eresp, tbl[n].ebusy,
                 tbl[n].eg,
                 tbl[n].ebusy ? req_address[g] : 32'h0,
                 tbl[n].ebusy ? req_wdata[g] : 32'h0,
                 tbl[n].ebusy ? req_byte_enable[g] : 4'h0, er);
      step();
    end

    // Reset two cycles into a read by port 2, then a late resp, then re-arbitration.
    req_read = 4'b0100;
    mem_resp = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check_outs("rst_mid", 0, 0, 4'b0, 0, 2'd0, 32'h0, 32'h0, 4'h0, 128'h0);
    step();
    rst = 1'b0;
    req_read = 4'b0000;
    mem_resp = 1'b1;
    #1;
    check_outs("late_resp", 0, 0, 4'b0, 0, 2'd0, 32'h0, 32'h0, 4'h0, 128'h0);
    step();
    mem_resp = 1'b0;
    req_read = 4'b1111;
    step();
    check_outs("restart", 1, 0, 4'b0, 1, 2'd0, 32'h100, 32'h1234_5678, 4'b0011,
               {96'h0, 32'hDEAD_BEEF});
    mem_resp = 1'b1;
    step();
    req_read = 4'b0000;
    mem_resp = 1'b0;

    // Randomised run against the reference model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_busy = 1'b0;
    m_g    = 0;
    m_last = NP - 1;
    act  = '0;
    cool = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NP; i++) begin
        if (cool[i]) begin
          req_read[i]  = 1'b0;
          req_write[i] = 1'b0;
          act[i]  = 1'b0;
          cool[i] = 1'b0;
        end else if (!act[i] && $urandom_range(0, 2) == 0) begin
          act[i] = 1'b1;
          kind = 2'($urandom_range(1, 3));
          req_read[i]        = kind[0];
          req_write[i]       = kind[1];
          req_address[i]     = $urandom;
          req_wdata[i]       = $urandom;
          req_byte_enable[i] = 4'($urandom_range(0, 15));
        end
      end
      mem_resp  = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      #1;
      model_check($sformatf("rnd%0d", c));
      if (m_busy && mem_resp) cool[m_g] = 1'b1;
      model_advance();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
